// File: rtl/ddr3_req_sched.sv
// ddr3_req_sched
//   Arbitrates between a write command port and a read command port in front
//   of a DDR3 command FSM. Multi-command sequences (closed by lst=1) are never
//   split. The bus direction changes only when the opposite side is waiting
//   and either the current side has gone quiet or it has used up its
//   MAX_BURSTS sequences. Every direction change inserts TURN_CYCLES idle
//   cycles.
//
// Ports
//   clock, reset_n              rising-edge clock, async active-low reset
//   wr_req_i/ack_o/lst_i/tid_i/adr_i   write command port (req/ack handshake)
//   rd_req_i/ack_o/lst_i/tid_i/adr_i   read command port (req/ack handshake)
//   cmd_valid_o, cmd_ready_i    command handshake towards the DDR3 FSM
//   cmd_write_o, cmd_last_o,
//   cmd_tid_o, cmd_adr_o        command payload, muxed from the active port
//   turn_o                      high while the bus is turning around
//
// State | meaning
//   IDLE | no direction chosen since reset
//   WR   | serving the write port
//   RD   | serving the read port
//   TURN | bus turnaround; count down, then enter the latched target
module ddr3_req_sched #(
  parameter int ADDRS        = 32,
  parameter int MEM_ID_WIDTH = 4,
  parameter int TURN_CYCLES  = 2,
  parameter int MAX_BURSTS   = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wr_req_i,
  output logic                    wr_ack_o,
  input  logic                    wr_lst_i,
  input  logic [MEM_ID_WIDTH-1:0] wr_tid_i,
  input  logic [ADDRS-1:0]        wr_adr_i,
  input  logic                    rd_req_i,
  output logic                    rd_ack_o,
  input  logic                    rd_lst_i,
  input  logic [MEM_ID_WIDTH-1:0] rd_tid_i,
  input  logic [ADDRS-1:0]        rd_adr_i,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  output logic                    cmd_write_o,
  output logic                    cmd_last_o,
  output logic [MEM_ID_WIDTH-1:0] cmd_tid_o,
  output logic [ADDRS-1:0]        cmd_adr_o,
  output logic                    turn_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WR   = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_TURN = 2'd3;

  localparam logic       TGT_RD      = 1'b0;
  localparam logic       TGT_WR      = 1'b1;
  localparam logic [7:0] BURST_MAX   = 8'(MAX_BURSTS);
  localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES);
  localparam logic       TURN_BYPASS = (TURN_CYCLES == 0);

  logic [1:0] state_q, state_d;
  logic       target_q, target_d;
  logic       seq_open_q, seq_open_d;
  logic [7:0] burst_q, burst_d;
  logic [3:0] turn_cnt_q, turn_cnt_d;

  logic       in_wr, in_rd;
  logic       own_req, own_lst, opp_req, accept;
  logic       seq_open_acc;
  logic [7:0] burst_acc;

  assign in_wr = (state_q == ST_WR);
  assign in_rd = (state_q == ST_RD);

  assign own_req = in_wr ? wr_req_i : rd_req_i;
  assign own_lst = in_wr ? wr_lst_i : rd_lst_i;
  assign opp_req = in_wr ? rd_req_i : wr_req_i;
  assign accept  = (in_wr | in_rd) & own_req & cmd_ready_i;

  assign cmd_valid_o = (in_wr & wr_req_i) | (in_rd & rd_req_i);
  assign wr_ack_o    = in_wr & wr_req_i & cmd_ready_i;
  assign rd_ack_o    = in_rd & rd_req_i & cmd_ready_i;
  assign cmd_write_o = in_wr;
  assign cmd_last_o  = own_lst;
  assign cmd_tid_o   = in_wr ? wr_tid_i : rd_tid_i;
  assign cmd_adr_o   = in_wr ? wr_adr_i : rd_adr_i;
  assign turn_o      = (state_q == ST_TURN);

  // Flag and burst count as they stand after this cycle's accept; the
  // switch decision looks at these so a closing lst=1 can trigger a turn
  // in the same cycle.
  always_comb begin
    seq_open_acc = seq_open_q;
    burst_acc    = burst_q;
    if (accept) begin
      seq_open_acc = ~own_lst;
      if (own_lst && (burst_q != BURST_MAX)) begin
        burst_acc = burst_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    seq_open_d = seq_open_q;
    burst_d    = burst_q;
    turn_cnt_d = turn_cnt_q;
    case (state_q)
      ST_IDLE: begin
        seq_open_d = 1'b0;
        burst_d    = 8'd0;
        if (rd_req_i) begin
          state_d = ST_RD;
        end else if (wr_req_i) begin
          state_d = ST_WR;
        end
      end
      ST_WR, ST_RD: begin
        seq_open_d = seq_open_acc;
        burst_d    = burst_acc;
        if (!seq_open_acc && opp_req && (!own_req || (burst_acc == BURST_MAX))) begin
          target_d = in_rd ? TGT_WR : TGT_RD;
          burst_d  = 8'd0;
          if (TURN_BYPASS) begin
            state_d = in_rd ? ST_WR : ST_RD;
          end else begin
            state_d    = ST_TURN;
            turn_cnt_d = TURN_LOAD;
          end
        end
      end
      ST_TURN: begin
        // Loaded with TURN_CYCLES on entry; the cycle that sees 1 is the last.
        if (turn_cnt_q <= 4'd1) begin
          state_d    = (target_q == TGT_WR) ? ST_WR : ST_RD;
          turn_cnt_d = 4'd0;
          seq_open_d = 1'b0;
          burst_d    = 8'd0;
        end else begin
          turn_cnt_d = turn_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      target_q   <= TGT_RD;
      seq_open_q <= 1'b0;
      burst_q    <= 8'd0;
      turn_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      seq_open_q <= seq_open_d;
      burst_q    <= burst_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

endmodule

// File: tb/tb_ddr3_req_sched.sv
// tb_ddr3_req_sched
//   Three scheduler instances share one set of inputs:
//     0: TURN_CYCLES=2, MAX_BURSTS=8   1: TURN_CYCLES=2, MAX_BURSTS=2
//     2: TURN_CYCLES=0, MAX_BURSTS=8
//   A vector table exercises instance 0, hand sequences cover the
//   burst-limit and turnaround cases on all three, and a random phase checks
//   every instance each cycle against a direction/turnaround reference model.
module tb_ddr3_req_sched;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        wr_req, wr_lst, rd_req, rd_lst, cmd_ready;
  logic [3:0]  wr_tid, rd_tid;
  logic [31:0] wr_adr, rd_adr;

  logic        valid_a [3];
  logic        write_a [3];
  logic        last_a  [3];
  logic        wack_a  [3];
  logic        rack_a  [3];
  logic        turn_a  [3];
  logic [3:0]  tid_a   [3];
  logic [31:0] adr_a   [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  ddr3_req_sched #(.ADDRS(32), .MEM_ID_WIDTH(4), .TURN_CYCLES(2), .MAX_BURSTS(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_req_i(wr_req), .wr_ack_o(wack_a[0]), .wr_lst_i(wr_lst), .wr_tid_i(wr_tid), .wr_adr_i(wr_adr),
    .rd_req_i(rd_req), .rd_ack_o(rack_a[0]), .rd_lst_i(rd_lst), .rd_tid_i(rd_tid), .rd_adr_i(rd_adr),
    .cmd_valid_o(valid_a[0]), .cmd_ready_i(cmd_ready), .cmd_write_o(write_a[0]),
    .cmd_last_o(last_a[0]), .cmd_tid_o(tid_a[0]), .cmd_adr_o(adr_a[0]), .turn_o(turn_a[0]));

  ddr3_req_sched #(.ADDRS(32), .MEM_ID_WIDTH(4), .TURN_CYCLES(2), .MAX_BURSTS(2)) dut_m2 (
    .clock(clock), .reset_n(reset_n),
    .wr_req_i(wr_req), .wr_ack_o(wack_a[1]), .wr_lst_i(wr_lst), .wr_tid_i(wr_tid), .wr_adr_i(wr_adr),
    .rd_req_i(rd_req), .rd_ack_o(rack_a[1]), .rd_lst_i(rd_lst), .rd_tid_i(rd_tid), .rd_adr_i(rd_adr),
    .cmd_valid_o(valid_a[1]), .cmd_ready_i(cmd_ready), .cmd_write_o(write_a[1]),
    .cmd_last_o(last_a[1]), .cmd_tid_o(tid_a[1]), .cmd_adr_o(adr_a[1]), .turn_o(turn_a[1]));

  ddr3_req_sched #(.ADDRS(32), .MEM_ID_WIDTH(4), .TURN_CYCLES(0), .MAX_BURSTS(8)) dut_t0 (
    .clock(clock), .reset_n(reset_n),
    .wr_req_i(wr_req), .wr_ack_o(wack_a[2]), .wr_lst_i(wr_lst), .wr_tid_i(wr_tid), .wr_adr_i(wr_adr),
    .rd_req_i(rd_req), .rd_ack_o(rack_a[2]), .rd_lst_i(rd_lst), .rd_tid_i(rd_tid), .rd_adr_i(rd_adr),
    .cmd_valid_o(valid_a[2]), .cmd_ready_i(cmd_ready), .cmd_write_o(write_a[2]),
    .cmd_last_o(last_a[2]), .cmd_tid_o(tid_a[2]), .cmd_adr_o(adr_a[2]), .turn_o(turn_a[2]));

  function automatic int t_of(int k);
    return (k == 2) ? 0 : 2;
  endfunction

  function automatic int m_of(int k);
    return (k == 1) ? 2 : 8;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h expected %0h @%0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: which side is being served (-1 none, 0 read, 1 write),
  // how many turnaround cycles remain, and where the turnaround leads.
  typedef struct {
    int serving;
    int gap_left;
    int dest;
    bit open;
    int bursts;
  } ref_t;

  ref_t mdl [3];

  function automatic ref_t ref_reset();
    ref_t r;
    r.serving = -1; r.gap_left = 0; r.dest = 0; r.open = 1'b0; r.bursts = 0;
    return r;
  endfunction

  function automatic ref_t ref_step(ref_t r, int t, int m);
    ref_t n = r;
    bit own, lst, opp;
    if (r.gap_left > 0) begin
      n.gap_left = r.gap_left - 1;
      if (n.gap_left == 0) begin
        n.serving = r.dest; n.bursts = 0; n.open = 1'b0;
      end
    end else if (r.serving < 0) begin
      if (rd_req) n.serving = 0;
      else if (wr_req) n.serving = 1;
      n.bursts = 0;
    end else begin
      own = (r.serving == 1) ? wr_req : rd_req;
      lst = (r.serving == 1) ? wr_lst : rd_lst;
      opp = (r.serving == 1) ? rd_req : wr_req;
      if (own && cmd_ready) begin
        n.open = !lst;
        if (lst) n.bursts = (r.bursts + 1 > m) ? m : r.bursts + 1;
      end
      if (!n.open && opp && (!own || n.bursts == m)) begin
        n.bursts = 0;
        n.dest = 1 - r.serving;
        if (t == 0) begin
          n.serving = n.dest;
        end else begin
          n.serving = -1;
          n.gap_left = t;
        end
      end
    end
    return n;
  endfunction

  task automatic cmp_model(input int k);
    int s = mdl[k].serving;
    chk("valid",  k, valid_a[k], (s == 1 && wr_req) || (s == 0 && rd_req));
    chk("write",  k, write_a[k], s == 1);
    chk("last",   k, last_a[k],  (s == 1) ? wr_lst : rd_lst);
    chk("tid",    k, tid_a[k],   (s == 1) ? wr_tid : rd_tid);
    chk("adr",    k, adr_a[k],   (s == 1) ? wr_adr : rd_adr);
    chk("wr_ack", k, wack_a[k],  s == 1 && wr_req && cmd_ready);
    chk("rd_ack", k, rack_a[k],  s == 0 && rd_req && cmd_ready);
    chk("turn",   k, turn_a[k],  mdl[k].gap_left > 0);
  endtask

  task automatic chk_reset_outs(input string nm);
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_valid"}, k, valid_a[k], 1'b0);
      chk({nm, "_wack"},  k, wack_a[k],  1'b0);
      chk({nm, "_rack"},  k, rack_a[k],  1'b0);
      chk({nm, "_turn"},  k, turn_a[k],  1'b0);
    end
  endtask

  // Reset pulse across one rising edge; returns at a falling edge with
  // reset released.
  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit rst; bit wr; bit wl; bit rd; bit rl; bit rdy;
    bit e_v; bit e_w; bit e_wa; bit e_ra; bit e_t;
  } vec_t;

  vec_t tbl [$];

  // Burst/turnaround measurement with both sides requesting single-command
  // sequences. drop=1 lowers rd_req right after the first read accept.
  task automatic seq_check(input bit drop, input string nm);
    int n_rd [3];
    int last_rd [3];
    int first_wr [3];
    int n_turn [3];
    for (int k = 0; k < 3; k++) begin
      n_rd[k] = 0; last_rd[k] = -1; first_wr[k] = -1; n_turn[k] = 0;
    end
    wr_req = 1'b0; rd_req = 1'b0; cmd_ready = 1'b1;
    pulse_reset();
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clock);
      wr_req = 1'b1; wr_lst = 1'b1; rd_lst = 1'b1; cmd_ready = 1'b1;
      rd_req = drop ? (c < 2) : 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
        if (first_wr[k] < 0) begin
          if (rack_a[k]) begin n_rd[k]++; last_rd[k] = c; end
          if (turn_a[k]) n_turn[k]++;
          if (wack_a[k]) first_wr[k] = c;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      chk({nm, "_wr_seen"}, k, first_wr[k] >= 0, 1'b1);
      chk({nm, "_rd_count"}, k, n_rd[k], drop ? 1 : m_of(k));
      chk({nm, "_gap"}, k, first_wr[k] - last_rd[k], t_of(k) + (drop ? 2 : 1));
      chk({nm, "_turn_cycles"}, k, n_turn[k], t_of(k));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    wr_req = 1'b0; wr_lst = 1'b0; rd_req = 1'b0; rd_lst = 1'b0; cmd_ready = 1'b0;
    wr_tid = 4'd9; rd_tid = 4'd5; wr_adr = 32'h0000_9000; rd_adr = 32'h0000_5000;
    #1;
    chk_reset_outs("reset");
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // fields: rst wr wl rd rl rdy | valid write wr_ack rd_ack turn
    // single write from idle: valid/ack on the second cycle
    tbl.push_back('{1,1,1,0,0,1, 0,0,0,0,0});
    tbl.push_back('{0,1,1,0,0,1, 1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,1, 0,1,0,0,0});
    // both from idle: read first, then a 2-cycle turn and the write
    tbl.push_back('{1,1,1,1,1,1, 0,0,0,0,0});
    tbl.push_back('{0,1,1,1,1,1, 1,0,0,1,0});
    tbl.push_back('{0,1,1,0,0,1, 0,0,0,0,0});
    tbl.push_back('{0,1,1,0,0,1, 0,0,0,0,1});
    tbl.push_back('{0,1,1,0,0,1, 0,0,0,0,1});
    tbl.push_back('{0,1,1,0,0,1, 1,1,1,0,0});
    tbl.push_back('{0,0,0,0,0,1, 0,1,0,0,0});
    // 3-command read with write pending; requests flip during the turn
    tbl.push_back('{1,1,1,1,0,1, 0,0,0,0,0});
    tbl.push_back('{0,1,1,1,0,1, 1,0,0,1,0});
    tbl.push_back('{0,1,1,1,0,1, 1,0,0,1,0});
    tbl.push_back('{0,1,1,1,1,1, 1,0,0,1,0});
    tbl.push_back('{0,1,1,0,0,1, 0,0,0,0,0});
    tbl.push_back('{0,0,0,1,1,1, 0,0,0,0,1});
    tbl.push_back('{0,0,0,1,1,1, 0,0,0,0,1});
    tbl.push_back('{0,1,1,1,1,1, 1,1,1,0,0});
    // ready low for 5 cycles inside an open read sequence
    tbl.push_back('{1,0,0,1,0,1, 0,0,0,0,0});
    tbl.push_back('{0,0,0,1,0,1, 1,0,0,1,0});
    for (int i = 0; i < 5; i++) tbl.push_back('{0,1,1,1,0,0, 1,0,0,0,0});
    tbl.push_back('{0,1,1,1,1,1, 1,0,0,1,0});
    tbl.push_back('{0,1,1,0,0,1, 0,0,0,0,0});
    tbl.push_back('{0,1,1,0,0,1, 0,0,0,0,1});

    foreach (tbl[i]) begin
      if (tbl[i].rst) pulse_reset();
      else @(negedge clock);
      wr_req = tbl[i].wr; wr_lst = tbl[i].wl;
      rd_req = tbl[i].rd; rd_lst = tbl[i].rl; cmd_ready = tbl[i].rdy;
      #1;
      chk("tbl_valid",  i, valid_a[0], tbl[i].e_v);
      chk("tbl_write",  i, write_a[0], tbl[i].e_w);
      chk("tbl_wr_ack", i, wack_a[0],  tbl[i].e_wa);
      chk("tbl_rd_ack", i, rack_a[0],  tbl[i].e_ra);
      chk("tbl_turn",   i, turn_a[0],  tbl[i].e_t);
      chk("tbl_tid",    i, tid_a[0],   tbl[i].e_w ? 4'd9 : 4'd5);
      chk("tbl_adr",    i, adr_a[0],   tbl[i].e_w ? 32'h0000_9000 : 32'h0000_5000);
    end

    seq_check(1'b0, "sat");
    seq_check(1'b1, "drop");

    // random phase against the reference model, with occasional resets
    wr_req = 1'b0; rd_req = 1'b0;
    pulse_reset();
    for (int k = 0; k < 3; k++) mdl[k] = ref_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c > 0) @(negedge clock);
      if ($urandom_range(0, 249) == 0) begin
        reset_n = 1'b0;
        #1;
        chk_reset_outs("rand_reset");
        for (int k = 0; k < 3; k++) mdl[k] = ref_reset();
        @(negedge clock);
        reset_n = 1'b1;
      end
      wr_req    = ($urandom_range(0, 9) < 6);
      rd_req    = ($urandom_range(0, 9) < 6);
      wr_lst    = ($urandom_range(0, 2) == 0);
      rd_lst    = ($urandom_range(0, 2) == 0);
      cmd_ready = ($urandom_range(0, 3) != 0);
      wr_tid    = 4'($urandom);
      rd_tid    = 4'($urandom);
      wr_adr    = $urandom;
      rd_adr    = $urandom;
      #1;
      for (int k = 0; k < 3; k++) begin
        cmp_model(k);
        mdl[k] = ref_step(mdl[k], t_of(k), m_of(k));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
